// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the encoder stream and the syndrome decoder.
// Codeword layout: bits [3:0] carry d3..d0, bits [6:4] carry p2..p0.
package hamming_pkg;

   localparam int DATA_W = 4;
   localparam int PAR_W  = 3;
   localparam int CODE_W = DATA_W + PAR_W;

   typedef logic [CODE_W-1:0] code_t;

   typedef enum logic [1:0] {
      EMPTY,
      HALF,
      FULL
   } skid_state_e;

   // Parity placement keeps decoder syndromes 1/2/4 pointing at bits 4/5/6.
   function automatic code_t hamming_encode(input logic [DATA_W-1:0] d);
      logic [PAR_W-1:0] p;
      p[0] = d[0] ^ d[1] ^ d[2];
      p[1] = d[1] ^ d[2] ^ d[3];
      p[2] = d[0] ^ d[1] ^ d[3];
      return {p, d};
   endfunction

endpackage

// File: rtl/hamming_skid_buf.sv
// Two-entry skid buffer for codewords: full throughput under backpressure, strict FIFO order,
// and an in_ready that comes from a flop so out_ready never reaches it combinationally.
module hamming_skid_buf
   import hamming_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] out_data
);

   skid_state_e       state;
   skid_state_e       next_state;
   logic [CODE_W-1:0] head_q;
   logic [CODE_W-1:0] skid_q;
   logic              ready_q;
   logic              accept;
   logic              transfer;
   logic              load_head;
   logic              load_skid;
   logic              pop_skid;

   assign out_valid = (state != EMPTY);
   assign out_data  = head_q;
   assign in_ready  = ready_q;
   assign accept    = in_valid && ready_q;
   assign transfer  = out_valid && out_ready;

   always_comb begin
      next_state = state;
      load_head  = 1'b0;
      load_skid  = 1'b0;
      pop_skid   = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               next_state = HALF;
               load_head  = 1'b1;
            end
         end
         HALF: begin
            if (accept && !transfer) begin
               next_state = FULL;
               load_skid  = 1'b1;
            end else if (!accept && transfer) begin
               next_state = EMPTY;
            end else if (accept && transfer) begin
               load_head = 1'b1;
            end
         end
         FULL: begin
            if (transfer) begin
               next_state = HALF;
               pop_skid   = 1'b1;
            end
         end
         default: next_state = EMPTY;
      endcase
   end

   // ready_q stays low through reset and rises on the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         ready_q <= 1'b0;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state   <= next_state;
         ready_q <= (next_state != FULL);
         if (load_head) begin
            head_q <= in_data;
         end else if (pop_skid) begin
            head_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/hamming_encoder_stream.sv
// Streaming Hamming(7,4) encoder with skid buffering and a running count of delivered codewords.
// Define ERR_INJECT_EN to add a one-shot single-bit error injector (inj_arm/inj_pos/inj_done).
module hamming_encoder_stream
   import hamming_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] out_code,
   output logic [CNT_W-1:0]  word_cnt,
   output logic              busy
`ifdef ERR_INJECT_EN
   ,
   input  logic              inj_arm,
   input  logic [2:0]        inj_pos,
   output logic              inj_done
`endif
);

   if (DEPTH != 2) begin : g_bad_depth
      $error("hamming_encoder_stream: DEPTH must be 2");
   end

   logic [CODE_W-1:0] enc_code;
   logic              accept;

   assign accept = in_valid && in_ready;

`ifdef ERR_INJECT_EN
   logic       armed_q;
   logic [2:0] pos_q;

   // Position 7 shifts the single set bit past the codeword, giving a clean word.
   assign enc_code = hamming_encode(in_data)
                   ^ (armed_q ? code_t'(8'd1 << pos_q) : code_t'(0));
   assign inj_done = accept && armed_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q <= 1'b0;
         pos_q   <= 3'd7;
      end else if (inj_arm) begin
         armed_q <= 1'b1;
         pos_q   <= inj_pos;
      end else if (accept) begin
         armed_q <= 1'b0;
      end
   end
`else
   assign enc_code = hamming_encode(in_data);
`endif

   hamming_skid_buf u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (enc_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_code)
   );

   assign busy = out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
      end else if (out_valid && out_ready) begin
         word_cnt <= word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Self-checking bench for hamming_encoder_stream: a generator-matrix model with a FIFO scoreboard
// checked every cycle, plus directed latency, streaming, backpressure and reset scenarios.
module tb_hamming_encoder_stream;
   import hamming_pkg::*;

   // Narrow counter so the wrap from all-ones to zero is exercised by the random phase.
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       in_data = 4'h0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [6:0]       out_code;
   logic [CNT_W-1:0] word_cnt;
   logic             busy;
`ifdef ERR_INJECT_EN
   logic             inj_arm = 1'b0;
   logic [2:0]       inj_pos = 3'd7;
   logic             inj_done;
`endif

   int n_checks = 0;
   int n_pass = 0;
   int valid_cycles = 0;

   logic [6:0]       exp_q[$];
   logic [CNT_W-1:0] exp_cnt = '0;
   logic             ready_ok = 1'b0;

   hamming_encoder_stream #(.CNT_W(CNT_W), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .word_cnt  (word_cnt),
      .busy      (busy)
`ifdef ERR_INJECT_EN
      ,
      .inj_arm   (inj_arm),
      .inj_pos   (inj_pos),
      .inj_done  (inj_done)
`endif
   );

   always #5 clk = ~clk;

   // Codeword as the XOR of generator rows selected by the set data bits.
   function automatic logic [6:0] model_encode(input logic [3:0] d);
      logic [6:0] g [4];
      logic [6:0] c;
      g[0] = 7'h51;
      g[1] = 7'h72;
      g[2] = 7'h34;
      g[3] = 7'h68;
      c = 7'h00;
      for (int i = 0; i < 4; i++) begin
         if (d[i]) c = c ^ g[i];
      end
      return c;
   endfunction

   function automatic logic [2:0] syndrome(input logic [6:0] c);
      logic [2:0] s;
      s[0] = c[4] ^ c[0] ^ c[1] ^ c[2];
      s[1] = c[5] ^ c[1] ^ c[2] ^ c[3];
      s[2] = c[6] ^ c[0] ^ c[1] ^ c[3];
      return s;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] d, input logic r);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
   endtask

   // Scoreboard: predicted handshakes come from the model's own occupancy, never from the DUT.
   always @(negedge clk) begin
      logic m_in_ready;
      logic m_out_valid;
      if (!rst_n) begin
         checkOutput("rst_in_ready", in_ready, 0);
         checkOutput("rst_out_valid", out_valid, 0);
         checkOutput("rst_busy", busy, 0);
         checkOutput("rst_out_code", out_code, 0);
         checkOutput("rst_word_cnt", word_cnt, 0);
         exp_q.delete();
         exp_cnt  = '0;
         ready_ok = 1'b0;
      end else begin
         m_in_ready  = ready_ok && (exp_q.size() < 2);
         m_out_valid = (exp_q.size() != 0);
         checkOutput("in_ready", in_ready, m_in_ready);
         checkOutput("out_valid", out_valid, m_out_valid);
         checkOutput("busy", busy, m_out_valid);
         checkOutput("word_cnt", word_cnt, exp_cnt);
         if (m_out_valid) begin
            checkOutput("out_code", out_code, exp_q[0]);
            valid_cycles++;
         end
         if (m_out_valid && out_ready) begin
            checkOutput("syndrome", syndrome(out_code), 0);
            void'(exp_q.pop_front());
            exp_cnt = exp_cnt + 1'b1;
         end
         if (in_valid && m_in_ready) begin
            exp_q.push_back(model_encode(in_data));
         end
         ready_ok = 1'b1;
      end
   end

   initial begin
      checkOutput("model_0001", model_encode(4'h1), 7'h51);
      checkOutput("model_1111", model_encode(4'hF), 7'h7F);
      checkOutput("model_0110", model_encode(4'h6), 7'h46);
      checkOutput("model_1000", model_encode(4'h8), 7'h68);
      checkOutput("model_syn_bit2", syndrome(7'h55), 3);

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(0, 4'h0, 1);

      $display("[TB] single word latency");
      applyStimulus(1, 4'h1, 1);
      applyStimulus(0, 4'h0, 1);
      checkOutput("t1_out_valid", out_valid, 1);
      checkOutput("t1_out_code", out_code, 7'h51);
      checkOutput("t1_cnt_before", word_cnt, 0);
      applyStimulus(0, 4'h0, 1);
      checkOutput("t1_cnt_after", word_cnt, 1);
      checkOutput("t1_drained", out_valid, 0);

      $display("[TB] back-to-back stream");
      valid_cycles = 0;
      for (int d = 0; d < 16; d++) begin
         applyStimulus(1, 4'(d), 1);
      end
      applyStimulus(0, 4'h0, 1);
      applyStimulus(0, 4'h0, 1);
      checkOutput("t2_valid_cycles", valid_cycles, 16);
      checkOutput("t2_word_cnt", word_cnt, 17);

      $display("[TB] backpressure");
      applyStimulus(1, 4'h3, 0);
      applyStimulus(1, 4'h9, 0);
      applyStimulus(1, 4'hC, 0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("t3_in_ready_low", in_ready, 0);
         checkOutput("t3_head_stable", out_code, 7'h23);
         applyStimulus(1, 4'hC, 0);
      end
      applyStimulus(1, 4'hC, 1);
      applyStimulus(1, 4'hC, 1);
      applyStimulus(0, 4'h0, 1);
      applyStimulus(0, 4'h0, 1);
      checkOutput("t3_word_cnt", word_cnt, 20);
      checkOutput("t3_drained", out_valid, 0);

      $display("[TB] random traffic");
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 3) != 0));
      end

      $display("[TB] reset while full");
      applyStimulus(1, 4'h2, 0);
      applyStimulus(1, 4'h7, 0);
      applyStimulus(1, 4'h0, 0);
      checkOutput("t5_full", in_ready, 0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      checkOutput("t5_async_out_valid", out_valid, 0);
      checkOutput("t5_async_word_cnt", word_cnt, 0);
      checkOutput("t5_async_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(0, 4'h0, 1);
      applyStimulus(1, 4'h5, 1);
      applyStimulus(0, 4'h0, 1);
      checkOutput("t5_first_code", out_code, 7'h65);
      checkOutput("t5_first_valid", out_valid, 1);
      applyStimulus(0, 4'h0, 1);
      checkOutput("t5_word_cnt", word_cnt, 1);
      applyStimulus(0, 4'h0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
